// File: rtl/fm_demod_param.sv
// fm_demod_param: delay-multiply FM discriminator with two cascaded boxcar lowpass stages
// and gated peak-to-peak / hysteretic zero-crossing measurement.
module fm_demod_param #(
    parameter int DATA_W    = 10,
    parameter int DELAY     = 4,
    parameter int AVG_LOG2  = 3,
    parameter int OUT_W     = 16,
    parameter int OUT_SHIFT = 0,
    parameter int HYST      = 1000,
    parameter int GATE_LEN  = 1024
) (
    input  logic              clk_8m,
    input  logic              rst,
    input  logic [DATA_W-1:0] ad_data,
    input  logic              in_valid,
    output logic [OUT_W-1:0]  demod_out,
    output logic              out_valid,
    output logic [OUT_W:0]    pp_out,
    output logic [15:0]       zc_out,
    output logic              meas_valid
);
    localparam int SW1 = DATA_W + 1;
    localparam int PW  = 2 * SW1;
    localparam int SW  = PW + AVG_LOG2;
    localparam int N   = 2 ** AVG_LOG2;
    localparam int GW  = $clog2(GATE_LEN);
    localparam logic signed [SW-1:0]    YMAX = SW'((2 ** (OUT_W - 1)) - 1);
    localparam logic signed [SW-1:0]    YMIN = -YMAX - SW'(1);
    localparam logic signed [OUT_W-1:0] HP   = OUT_W'(HYST);
    localparam logic signed [OUT_W-1:0] HN   = OUT_W'(-HYST);

    logic                    v1, v2, v3;
    logic signed [SW1-1:0]   s;
    logic signed [SW1-1:0]   dl [DELAY];
    logic signed [PW-1:0]    p;
    logic signed [PW-1:0]    buf1 [N];
    logic signed [PW-1:0]    buf2 [N];
    logic [AVG_LOG2-1:0]     ptr1, ptr2;
    logic signed [SW-1:0]    sum1, sum2, sum2_n, yf;
    logic signed [PW-1:0]    b;
    logic [OUT_W-1:0]        y_sat;
    logic [GW-1:0]           gcnt;
    logic signed [OUT_W-1:0] y, mx, mn, mx_n, mn_n;
    logic [15:0]             cnt, cnt_n;
    logic                    armed, armed_n, last, up;

    always_comb begin
        b      = PW'(sum1 >>> AVG_LOG2);
        sum2_n = sum2 + SW'(b) - SW'(buf2[ptr2]);
        yf     = sum2_n >>> (AVG_LOG2 + OUT_SHIFT);
        y_sat  = yf > YMAX ? OUT_W'(YMAX) : yf < YMIN ? OUT_W'(YMIN) : yf[OUT_W-1:0];
        y       = $signed(demod_out);
        last    = gcnt == GW'(GATE_LEN - 1);
        mx_n    = (gcnt == '0 || y > mx) ? y : mx;
        mn_n    = (gcnt == '0 || y < mn) ? y : mn;
        up      = armed && y >= HP;
        cnt_n   = (up && cnt != 16'hFFFF) ? cnt + 16'd1 : cnt;
        armed_n = up ? 1'b0 : (y < HN) ? 1'b1 : armed;
    end

    always_ff @(posedge clk_8m) begin
        if (rst) begin
            {v1, v2, v3, out_valid, meas_valid, armed} <= '0;
            s         <= '0;
            p         <= '0;
            sum1      <= '0;
            sum2      <= '0;
            ptr1      <= '0;
            ptr2      <= '0;
            demod_out <= '0;
            gcnt      <= '0;
            mx        <= '0;
            mn        <= '0;
            cnt       <= '0;
            pp_out    <= '0;
            zc_out    <= '0;
            for (int k = 0; k < DELAY; k++) dl[k] <= '0;
            for (int k = 0; k < N; k++) begin
                buf1[k] <= '0;
                buf2[k] <= '0;
            end
        end else begin
            v1         <= in_valid;
            v2         <= v1;
            v3         <= v2;
            out_valid  <= v3;
            meas_valid <= out_valid && last;
            // offset removal: flipping the MSB of offset binary gives two's complement
            if (in_valid) s <= {~ad_data[DATA_W-1], ~ad_data[DATA_W-1], ad_data[DATA_W-2:0]};
            if (v1) begin
                p     <= PW'(s) * PW'(dl[DELAY-1]);
                dl[0] <= s;
                for (int k = 1; k < DELAY; k++) dl[k] <= dl[k-1];
            end
            if (v2) begin
                sum1       <= sum1 + SW'(p) - SW'(buf1[ptr1]);
                buf1[ptr1] <= p;
                ptr1       <= ptr1 + 1'b1;
            end
            if (v3) begin
                sum2       <= sum2_n;
                buf2[ptr2] <= b;
                ptr2       <= ptr2 + 1'b1;
                demod_out  <= y_sat;
            end
            // a gate's first sample reloads max/min; the closing sample still counts in its gate
            if (out_valid) begin
                gcnt  <= last ? '0 : gcnt + 1'b1;
                mx    <= mx_n;
                mn    <= mn_n;
                cnt   <= last ? '0 : cnt_n;
                armed <= armed_n;
                if (last) begin
                    pp_out <= (OUT_W + 1)'(mx_n) - (OUT_W + 1)'(mn_n);
                    zc_out <= cnt_n;
                end
            end
        end
    end
endmodule
